// File: rtl/hier_fanin_collector.sv
// hier_fanin_collector: one fan-in node of the hierarchical collection tree.
// Merges NUM_CHILDREN packet streams into a single upstream stream, tagging
// every beat with the index of its originating child. Arbitration is
// round-robin per packet, and a granted child owns the port until its last
// beat. The upstream side has one registered output stage.
// Optional feature macro: HIER_FANIN_STATS_EN enables per-child packet
// counters readable through stat_sel/stat_count. When it is undefined,
// stat_count is tied to 0.
module hier_fanin_collector #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 4,
    parameter int CNT_W        = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CHILDREN-1:0]        child_valid,
    output logic [NUM_CHILDREN-1:0]        child_ready,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
    input  logic [NUM_CHILDREN-1:0]        child_last,
    output logic                           up_valid,
    input  logic                           up_ready,
    output logic [DATA_W-1:0]              up_data,
    output logic                           up_last,
    output logic [ID_W-1:0]                up_src_id,
    output logic [CNT_W-1:0]               pkt_count,
    output logic                           busy,
    input  logic [ID_W-1:0]                stat_sel,
    output logic [CNT_W-1:0]               stat_count
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_lock_id;
    logic                  r_up_valid;
    logic [DATA_W-1:0]     r_up_data;
    logic                  r_up_last;
    logic [ID_W-1:0]       r_up_src_id;
    logic [CNT_W-1:0]      r_pkt_count;

    logic                    w_slot_free;
    logic                    w_found;
    logic [ID_W-1:0]         w_grant;
    logic [ID_W-1:0]         w_sel;
    logic                    w_sel_en;
    logic [NUM_CHILDREN-1:0] w_child_ready;
    logic                    w_take;
    logic [DATA_W-1:0]       w_sel_data;
    logic                    w_sel_last;

    // Successor of a child index in the round-robin ring
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] v_n;
        if (id >= ID_W'(NUM_CHILDREN - 1)) begin
            v_n = {ID_W{1'b0}};
        end else begin
            v_n = id + ID_W'(1);
        end
        return v_n;
    endfunction

    assign w_slot_free = !r_up_valid || up_ready;

    // Round-robin search: first valid child starting at r_rr_ptr, wrapping
    always_comb begin
        logic [ID_W:0] v_idx;
        logic          v_hit;
        w_found = 1'b0;
        w_grant = {ID_W{1'b0}};
        v_idx   = {(ID_W+1){1'b0}};
        v_hit   = 1'b0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (v_idx >= (ID_W+1)'(NUM_CHILDREN)) begin
                v_idx = v_idx - (ID_W+1)'(NUM_CHILDREN);
            end else begin
                v_idx = v_idx;
            end
            v_hit = 1'b0;
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                if ((ID_W+1)'(i) == v_idx) begin
                    v_hit = child_valid[i];
                end else begin
                    v_hit = v_hit;
                end
            end
            if (!w_found && v_hit) begin
                w_found = 1'b1;
                w_grant = v_idx[ID_W-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // Selected child (locked owner or fresh grant) and its ready strobe
    always_comb begin
        if (r_state == ST_LOCKED) begin
            w_sel    = r_lock_id;
            w_sel_en = !rst && w_slot_free;
        end else begin
            w_sel    = w_grant;
            w_sel_en = !rst && w_slot_free && w_found;
        end
        w_child_ready = {NUM_CHILDREN{1'b0}};
        w_sel_data    = {DATA_W{1'b0}};
        w_sel_last    = 1'b0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (ID_W'(i) == w_sel) begin
                w_child_ready[i] = w_sel_en;
                w_sel_data       = child_data[i*DATA_W +: DATA_W];
                w_sel_last       = child_last[i];
            end else begin
                w_child_ready[i] = 1'b0;
            end
        end
    end

    assign w_take = |(w_child_ready & child_valid);

    // Arbitration FSM, output register stage and packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= {ID_W{1'b0}};
            r_lock_id   <= {ID_W{1'b0}};
            r_up_valid  <= 1'b0;
            r_up_data   <= {DATA_W{1'b0}};
            r_up_last   <= 1'b0;
            r_up_src_id <= {ID_W{1'b0}};
            r_pkt_count <= {CNT_W{1'b0}};
        end else begin
            if (w_take) begin
                r_up_valid  <= 1'b1;
                r_up_data   <= w_sel_data;
                r_up_last   <= w_sel_last;
                r_up_src_id <= w_sel;
            end else if (up_ready) begin
                r_up_valid  <= 1'b0;
            end else begin
                r_up_valid  <= r_up_valid;
            end

            if (r_up_valid && up_ready && r_up_last) begin
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end else begin
                r_pkt_count <= r_pkt_count;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_take && w_sel_last) begin
                        r_rr_ptr <= next_ptr(w_sel);
                    end else if (w_take) begin
                        r_state   <= ST_LOCKED;
                        r_lock_id <= w_sel;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (w_take && w_sel_last) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= next_ptr(r_lock_id);
                    end else begin
                        r_state  <= ST_LOCKED;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign child_ready = w_child_ready;
    assign up_valid    = r_up_valid;
    assign up_data     = r_up_data;
    assign up_last     = r_up_last;
    assign up_src_id   = r_up_src_id;
    assign pkt_count   = r_pkt_count;
    assign busy        = (r_state == ST_LOCKED) || r_up_valid;

`ifdef HIER_FANIN_STATS_EN
    logic [CNT_W-1:0] r_child_cnt [NUM_CHILDREN];
    logic [CNT_W-1:0] r_stat_count;
    logic [CNT_W-1:0] w_stat_rd;

    // Stats readout mux; indices beyond the last child read as zero
    always_comb begin
        w_stat_rd = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (ID_W'(i) == stat_sel) begin
                w_stat_rd = r_child_cnt[i];
            end else begin
                w_stat_rd = w_stat_rd;
            end
        end
    end

    // Per-child completed-packet counters and the registered readout
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                r_child_cnt[i] <= {CNT_W{1'b0}};
            end
            r_stat_count <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CHILDREN; i++) begin
                if (w_child_ready[i] && child_valid[i] && child_last[i]) begin
                    r_child_cnt[i] <= r_child_cnt[i] + CNT_W'(1);
                end else begin
                    r_child_cnt[i] <= r_child_cnt[i];
                end
            end
            r_stat_count <= w_stat_rd;
        end
    end

    assign stat_count = r_stat_count;
`else
    // The stats select has no effect when the counters are not built
    logic w_stat_sel_unused;
    assign w_stat_sel_unused = ^stat_sel;
    assign stat_count        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hier_fanin_collector.sv
// Testbench for hier_fanin_collector. It uses a packet-level round-robin model
// with an expected-beat queue, a separate upstream monitor, directed boundary
// cases and randomized traffic.
module tb_hier_fanin_collector;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    child_valid = '0;
    logic [N-1:0]    child_ready;
    logic [N*DW-1:0] child_data = '0;
    logic [N-1:0]    child_last = '0;
    logic            up_valid;
    logic            up_ready = 1'b0;
    logic [DW-1:0]   up_data;
    logic            up_last;
    logic [IW-1:0]   up_src_id;
    logic [CW-1:0]   pkt_count;
    logic            busy;
    logic [IW-1:0]   stat_sel = '0;
    logic [CW-1:0]   stat_count;

    beat_t cq [N][$];
    exp_t  eq [$];
    int    model_rr = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    up_hs_total = 0;
    int    ready_mode = 0;
    bit    drop_mode = 1'b0;
    logic [CW-1:0] exp_pkt = '0;
    logic [CW-1:0] exp_stat = '0;
`ifdef HIER_FANIN_STATS_EN
    logic [CW-1:0] mcnt [N];
`endif

    hier_fanin_collector #(
        .NUM_CHILDREN(N), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .child_valid(child_valid), .child_ready(child_ready),
        .child_data(child_data), .child_last(child_last),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .up_last(up_last), .up_src_id(up_src_id), .pkt_count(pkt_count),
        .busy(busy), .stat_sel(stat_sel), .stat_count(stat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add_packet(input int c, input int len, input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = base + DW'(k);
            b.last  = (k == len - 1);
            b.first = (k == 0);
            cq[c].push_back(b);
        end
    endtask

    // Packet-level round robin over everything queued (all children valid at grant time)
    task automatic build_expected();
        int   idx [N];
        exp_t e;
        bit   any;
        for (int i = 0; i < N; i++) idx[i] = 0;
        for (int guard = 0; guard < 10000; guard++) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (model_rr + k) % N;
                if (!any && idx[c] < cq[c].size()) begin
                    any = 1'b1;
                    for (int g = 0; g < 64; g++) begin
                        e.data = cq[c][idx[c]].data;
                        e.last = cq[c][idx[c]].last;
                        e.id   = IW'(c);
                        eq.push_back(e);
                        idx[c]++;
                        if (e.last) break;
                    end
                    model_rr = (c + 1) % N;
                end
            end
            if (!any) break;
        end
    endtask

    function automatic bit all_idle();
        if (eq.size() != 0 || up_valid) return 1'b0;
        for (int i = 0; i < N; i++) if (cq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive at negedge, sample just before posedge, retire accepted beats
    task automatic cycle(input bit do_rst = 1'b0);
        logic [N-1:0] hs;
        @(negedge clk);
        rst = do_rst;
        if (do_rst) begin
            for (int i = 0; i < N; i++) cq[i].delete();
            eq.delete();
            model_rr = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (cq[i].size() > 0) begin
                child_data[i*DW +: DW] = cq[i][0].data;
                child_last[i]  = cq[i][0].last;
                child_valid[i] = !(drop_mode && !cq[i][0].first && ($urandom_range(0, 3) == 0));
            end else begin
                child_valid[i] = 1'b0;
                child_last[i]  = 1'b0;
            end
        end
        case (ready_mode)
            0: up_ready = 1'b1;
            1: up_ready = ($urandom_range(0, 9) < 7);
            default: up_ready = 1'b0;
        endcase
        stat_sel = IW'($urandom_range(0, 15));
        #4;
        hs = child_ready & child_valid;
        chk("ready_onehot", 64'($onehot0(child_ready)), 64'd1);
        if (up_valid && !up_ready) chk("ready_under_backpressure", 64'(child_ready), 64'd0);
        for (int i = 0; i < N; i++) begin
            if (hs[i] && !rst) void'(cq[i].pop_front());
        end
    endtask

    task automatic drain(input string nm, input int budget, output int used);
        used = 0;
        for (int n = 0; n < budget; n++) begin
            cycle();
            used++;
            if (all_idle()) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: drain timeout, %0d beats still expected", nm, eq.size());
        cycle(1'b1);
    endtask

    // Upstream monitor: pop and compare on each upstream handshake
    always begin
        exp_t e;
        bit   popped;
        @(negedge clk);
        #3;
        popped = 1'b0;
        chk("pkt_count", 64'(pkt_count), 64'(exp_pkt));
        chk("stat_count", 64'(stat_count), 64'(exp_stat));
        if (!rst && up_valid && up_ready) begin
            up_hs_total++;
            if (eq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %0h src %0d expected none", up_data, up_src_id);
            end else begin
                e = eq.pop_front();
                popped = 1'b1;
                chk("up_data", 64'(up_data), 64'(e.data));
                chk("up_last", 64'(up_last), 64'(e.last));
                chk("up_src_id", 64'(up_src_id), 64'(e.id));
            end
        end
        if (rst) begin
            exp_pkt  = '0;
            exp_stat = '0;
`ifdef HIER_FANIN_STATS_EN
            for (int i = 0; i < N; i++) mcnt[i] = '0;
`endif
        end else begin
            if (popped && e.last) exp_pkt = exp_pkt + CW'(1);
`ifdef HIER_FANIN_STATS_EN
            exp_stat = (int'(stat_sel) < N) ? mcnt[stat_sel] : '0;
            for (int i = 0; i < N; i++) begin
                if (child_ready[i] && child_valid[i] && child_last[i]) mcnt[i] = mcnt[i] + CW'(1);
            end
`else
            exp_stat = '0;
`endif
        end
    end

    initial begin
        int used;
        int base;
        cycle(1'b1);
        cycle(1'b1);
        chk("rst_up_valid", 64'(up_valid), 64'd0);
        chk("rst_up_data", 64'(up_data), 64'd0);
        chk("rst_up_last", 64'(up_last), 64'd0);
        chk("rst_up_src_id", 64'(up_src_id), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_child_ready", 64'(child_ready), 64'd0);
        chk("rst_stat_count", 64'(stat_count), 64'd0);

        // Single-beat packet from child 3, then rr pointer must sit at 4
        add_packet(3, 1, 32'hA5A5_0003);
        build_expected();
        cycle();
        chk("t1_grant3", 64'(child_ready), 64'h8);
        cycle();
        chk("t1_up_valid", 64'(up_valid), 64'd1);
        chk("t1_up_data", 64'(up_data), 64'hA5A5_0003);
        chk("t1_src", 64'(up_src_id), 64'd3);
        chk("t1_last", 64'(up_last), 64'd1);
        chk("t1_busy_idle", 64'(busy), 64'd1);
        drain("t1", 20, used);
        add_packet(2, 1, 32'h1100_0002);
        add_packet(5, 1, 32'h1100_0005);
        build_expected();
        drain("t1b", 20, used);

        // All children valid: strict rotation with rr wrap, full throughput
        cycle(1'b1);
        for (int i = 0; i < N; i++) add_packet(i, 1, 32'h3000_0000 + DW'(i));
        add_packet(0, 1, 32'h3000_0100);
        build_expected();
        drain("t3", 40, used);
        chk("t3_throughput_cycles", 64'(used), 64'd13);

        // Multi-beat lock: child 2 holds the port while child 5 waits
        add_packet(2, 4, 32'h4000_0020);
        add_packet(5, 1, 32'h4000_0050);
        build_expected();
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (cq[2].size() > 0) chk("t4_no_grant5", 64'(child_ready[5]), 64'd0);
            if (all_idle()) break;
        end
        chk("t4_drained", 64'(all_idle()), 64'd1);

        // Backpressure: beat 0x1234 held five cycles, then exactly one transfer
        ready_mode = 2;
        add_packet(7, 1, 32'h0000_1234);
        add_packet(2, 1, 32'h5000_0002);
        build_expected();
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (up_valid) break;
        end
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("t5_hold_valid", 64'(up_valid), 64'd1);
            chk("t5_hold_data", 64'(up_data), 64'h1234);
            chk("t5_hold_ready", 64'(child_ready), 64'd0);
        end
        ready_mode = 0;
        drain("t5", 20, used);

        // Reset in the middle of a 4-beat packet, then normal grant of child 7
        add_packet(6, 4, 32'h6000_0060);
        build_expected();
        base = up_hs_total;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (up_hs_total - base >= 2) break;
        end
        cycle(1'b1);
        cycle();
        chk("t6_up_valid", 64'(up_valid), 64'd0);
        chk("t6_pkt_count", 64'(pkt_count), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        add_packet(7, 1, 32'h7000_0007);
        build_expected();
        drain("t6", 20, used);

        // Random traffic with backpressure and mid-packet valid gaps
        ready_mode = 1;
        drop_mode  = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N; c++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) add_packet(c, $urandom_range(1, 4), DW'($urandom()));
            end
            build_expected();
            drain("rand", 600, used);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
